// File: rtl/rf_wb_if.sv
// Writeback-arbiter bus: the two writeback request channels, decode's
// issue/source-register lookups, and the registered regfile write port.
interface rf_wb_if;
  logic        wb0_valid;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data;
  logic        wb1_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  // Pipeline side: drives requests, issue and source registers.
  modport master (
    output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    output issue_valid, issue_rd, rs1, rs2,
    input  wb0_ready, wb1_ready, hazard, rf_we, rf_addr, rf_data
  );

  // Arbiter side.
  modport slave (
    input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
    input  issue_valid, issue_rd, rs1, rs2,
    output wb0_ready, wb1_ready, hazard, rf_we, rf_addr, rf_data
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Regfile writeback arbiter: LSU (src0) has fixed priority over ALU (src1),
// except when the ALU has been blocked STARVE_LIMIT cycles in a row. The winner
// is registered onto the regfile write port, and a busy scoreboard reports
// read-after-write hazards to decode. CNT_W must satisfy 2**CNT_W > STARVE_LIMIT.
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic     clk,
  input logic     reset,
  rf_wb_if.slave  wb
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]      busy_q, busy_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;

  logic             starve_hit;
  logic             grant0, grant1;
  logic [4:0]       g_rd;
  logic [31:0]      g_data;

  // Grant decision; readies are suppressed during reset so nothing is accepted.
  always_comb begin
    starve_hit = wb.wb1_valid && (starve_cnt_q == LIMIT);
    grant1     = !reset && wb.wb1_valid && (starve_hit || !wb.wb0_valid);
    grant0     = !reset && wb.wb0_valid && !starve_hit;
    g_rd       = grant1 ? wb.wb1_rd   : wb.wb0_rd;
    g_data     = grant1 ? wb.wb1_data : wb.wb0_data;
  end

  assign wb.wb0_ready = grant0;
  assign wb.wb1_ready = grant1;
  assign wb.hazard    = busy_q[wb.rs1] | busy_q[wb.rs2];
  assign wb.rf_we     = rf_we_q;
  assign wb.rf_addr   = rf_addr_q;
  assign wb.rf_data   = rf_data_q;

  // Next state: starvation counter, registered write port, busy scoreboard.
  always_comb begin
    if (wb.wb1_valid && !grant1) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
    end else begin
      starve_cnt_d = '0;
    end

    // A grant to x0 is accepted but never reaches the regfile.
    rf_we_d   = (grant0 || grant1) && (g_rd != 5'd0);
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (grant0 || grant1) begin
      rf_addr_d = g_rd;
      rf_data_d = g_data;
    end

    // Clear first, then set, so a newly issued producer of the same rd stays pending.
    busy_d = busy_q;
    if ((grant0 || grant1) && (g_rd != 5'd0)) busy_d[g_rd] = 1'b0;
    if (wb.issue_valid && (wb.issue_rd != 5'd0)) busy_d[wb.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
      busy_q       <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
    end
  end

endmodule
